// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a streamed program-load port and a 1-cycle fetch port.
// Optional IMEM_ADDR_WRAP_EN: out-of-range aligned fetches wrap modulo DEPTH.
module instr_mem_ctrl #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_fault,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_overflow,
  output logic [1:0]  state_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [DEPTH-1:0]      loaded_q, loaded_d;
  logic                  ovf_q, ovf_d;
  logic                  fv_q, fv_d;
  logic                  ff_q, ff_d;
  logic [31:0]           fi_q, fi_d;

  logic [31:0]           mem [DEPTH];
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  beat_ok;
  logic                  fetch_acc;
  logic                  misal;
  logic                  fault_c;

  assign load_ready    = (state_q == S_LOAD);
  assign fetch_ready   = (state_q == S_EMPTY) || (state_q == S_RUN);
  assign fetch_valid   = fv_q;
  assign fetch_instr   = fi_q;
  assign fetch_fault   = ff_q;
  assign load_overflow = ovf_q;
  assign state_o       = state_q;

  assign wr_idx    = wptr_q[ADDR_WIDTH-1:0];
  assign rd_idx    = fetch_addr[ADDR_WIDTH+1:2];
  assign beat_ok   = load_valid && load_ready && !load_start;
  assign fetch_acc = fetch_req && fetch_ready;
  assign misal     = |fetch_addr[1:0];

`ifdef IMEM_ADDR_WRAP_EN
  assign fault_c = misal;
`else
  logic oor;
  assign oor     = |fetch_addr[31:ADDR_WIDTH+2];
  assign fault_c = misal || oor;
`endif

  // Next state, write pointer, loaded mask and overflow flag
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    unique case (state_q)
      S_EMPTY: if (load_start) state_d = S_LOAD;
      S_LOAD:  if (beat_ok && load_last) state_d = S_RUN;
      S_RUN:   if (load_start) state_d = S_LOAD;
      default: state_d = S_EMPTY;
    endcase
    if (load_start) begin
      wptr_d   = '0;
      loaded_d = '0;
      ovf_d    = 1'b0;
    end else if (beat_ok) begin
      if (wptr_q < DEPTH_W) begin
        wr_en            = 1'b1;
        loaded_d[wr_idx] = 1'b1;
        wptr_d           = wptr_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Fetch response; reads see memory before any same-edge write
  always_comb begin
    fv_d = fetch_acc;
    fi_d = fi_q;
    ff_d = ff_q;
    if (fetch_acc) begin
      ff_d = fault_c;
      if (fault_c)
        fi_d = NOP_WORD;
      else if (loaded_q[rd_idx])
        fi_d = mem[rd_idx];
      else
        fi_d = NOP_WORD;
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      wptr_q   <= '0;
      loaded_q <= '0;
      ovf_q    <= 1'b0;
      fv_q     <= 1'b0;
      ff_q     <= 1'b0;
      fi_q     <= NOP_WORD;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
      fv_q     <= fv_d;
      ff_q     <= ff_d;
      fi_q     <= fi_d;
    end
  end

  // Storage array, masked by loaded_q rather than reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= load_data;
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl.
// Stimulus pushes expected fetch responses; a negedge monitor checks them.
module tb_instr_mem_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_overflow;
  logic [1:0]  state_o;

  exp_t        sb[$];
  logic [31:0] last_instr = NOP;
  int          n_total = 0;
  int          n_pass = 0;

  instr_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_overflow(load_overflow),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: pop on every response, check hold otherwise
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_instr = NOP;
    end else if (fetch_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got instr %h expected no response",
                 fetch_instr);
      end else begin
        e = sb.pop_front();
        chk("fetch_instr", fetch_instr, e.instr);
        chk("fetch_fault", 32'(fetch_fault), 32'(e.fault));
        last_instr = e.instr;
      end
    end else begin
      chk("instr_hold", fetch_instr, last_instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei,
                       input logic ef);
    exp_t e;
    e.instr = ei;
    e.fault = ef;
    sb.push_back(e);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_instr", fetch_instr, NOP);
    chk("rst_ovf", 32'(load_overflow), 0);
    chk("rst_fready", 32'(fetch_ready), 1);
    chk("rst_lready", 32'(load_ready), 0);
    rst_n = 1'b1;
    tick();

    fetch(32'h0, NOP, 1'b0);
    tick();

    start();
    chk("load_state", 32'(state_o), 1);
    chk("load_lready", 32'(load_ready), 1);
    chk("load_fready", 32'(fetch_ready), 0);
    beat(32'h0041_8293, 1'b0);
    beat(32'h4094_03B3, 1'b0);
    beat(32'h0041_C433, 1'b1);
    chk("run_state", 32'(state_o), 2);

    fetch(32'h8, 32'h0041_C433, 1'b0);
    fetch(32'h0, 32'h0041_8293, 1'b0);
    fetch(32'h4, 32'h4094_03B3, 1'b0);
    fetch(32'hC, NOP, 1'b0);
    fetch(32'h6, NOP, 1'b1);
`ifdef IMEM_ADDR_WRAP_EN
    fetch(32'h100, 32'h0041_8293, 1'b0);
`else
    fetch(32'h100, NOP, 1'b1);
`endif
    tick();

    load_start = 1'b1;
    fetch(32'h4, 32'h4094_03B3, 1'b0);
    load_start = 1'b0;
    chk("restart_state", 32'(state_o), 1);

    for (int i = 0; i < 65; i++)
      beat(32'hC000_0000 | 32'(i), i == 64);
    chk("ovf_flag", 32'(load_overflow), 1);
    chk("ovf_state", 32'(state_o), 2);
    fetch(32'hFC, 32'hC000_003F, 1'b0);
    fetch(32'h0, 32'hC000_0000, 1'b0);
    tick();

    start();
    beat(32'h1111_1111, 1'b0);
    beat(32'h2222_2222, 1'b0);
    load_valid = 1'b1;
    load_data  = 32'h3333_3333;
    load_last  = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("lstart_drop_state", 32'(state_o), 1);
    beat(32'h4444_4444, 1'b1);
    chk("relo_state", 32'(state_o), 2);
    chk("relo_ovf", 32'(load_overflow), 0);
    fetch(32'h0, 32'h4444_4444, 1'b0);
    fetch(32'h4, NOP, 1'b0);
    tick();

    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    tick();
    fetch_req = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("abort_valid", 32'(fetch_valid), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    start();
    beat(32'hDEAD_BEEF, 1'b0);
    beat(32'hCAFE_F00D, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midload_state", 32'(state_o), 0);
    chk("midload_lready", 32'(load_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch(32'h0, NOP, 1'b0);
    fetch(32'h4, NOP, 1'b0);

    repeat (4) tick();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
